// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    // Width of each grant statistics counter.
    localparam int unsigned STAT_W = 16;

    // Requester index of each core within the core_* port vectors.
    localparam int unsigned REQ_C0 = 0;
    localparam int unsigned REQ_C1 = 1;

    // Tenure grant counter width and its saturation value.
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    // Current owner of the memory port.
    typedef enum logic [1:0] {
        OwnIdle = 2'd0,
        OwnLd   = 2'd1,
        OwnC0   = 2'd2,
        OwnC1   = 2'd3
    } own_e;

    // Owner encoding for a core index.
    function automatic own_e core_own(input logic idx);
        return idx ? OwnC1 : OwnC0;
    endfunction

    // Tenure count increment that sticks at CNT_MAX.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating event counter with synchronous reset; used for grant statistics.
module mem_arb_sat_cnt
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_q;

    // Count enabled events, holding at all-ones once reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {STAT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: loader has absolute priority, the two cores share the
// port round-robin with a bounded burst per tenure. Reads return one cycle after grant.
// Optional grant statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_req,
    input  logic [AW-1:0]       ld_addr,
    input  logic [DW-1:0]       ld_wdata,
    output logic                ld_gnt,
    input  logic [1:0]          core_req,
    input  logic [1:0]          core_we,
    input  logic [2*AW-1:0]     core_addr,
    input  logic [2*DW-1:0]     core_wdata,
    output logic [1:0]          core_gnt,
    output logic [1:0]          core_rvalid,
    output logic [DW-1:0]       rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic [3*STAT_W-1:0] stat_gnt
);

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);

    own_e             own_q, own_d;
    logic             last_core_q, last_core_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rv_q;

    logic own_is_core;
    logic own_idx;
    logic keep;
    logic win_ld;
    logic win_core;
    logic win_idx;

    // The current owner keeps the port unless its burst is spent and the other core waits.
    assign own_is_core = (own_q == OwnC0) || (own_q == OwnC1);
    assign own_idx     = (own_q == OwnC1);
    assign keep        = own_is_core && core_req[own_idx] &&
                         ((cnt_q < BURST_CNT) || !core_req[~own_idx]);

    // Winner selection and next ownership/tenure state.
    always_comb begin
        own_d       = own_q;
        last_core_d = last_core_q;
        cnt_d       = cnt_q;
        win_ld      = 1'b0;
        win_core    = 1'b0;
        win_idx     = 1'b0;
        if (reset) begin
            // No grants while in reset; state is cleared by the register process.
            own_d = OwnIdle;
        end else if (ld_req) begin
            win_ld = 1'b1;
            cnt_d  = '0;
            own_d  = OwnLd;
        end else begin
            if (keep) begin
                win_core = 1'b1;
                win_idx  = own_idx;
            end else if (|core_req) begin
                win_core = 1'b1;
                win_idx  = (&core_req) ? ~last_core_q : core_req[REQ_C1];
            end
            if (win_core) begin
                if (own_q == core_own(win_idx)) begin
                    cnt_d = cnt_inc(cnt_q);
                end else begin
                    cnt_d = CNT_W'(1);
                    own_d = core_own(win_idx);
                end
                last_core_d = win_idx;
            end else begin
                own_d = OwnIdle;
                cnt_d = '0;
            end
        end
    end

    // Memory-side mux and grant strobes; everything is zero without a winner.
    always_comb begin
        ld_gnt    = win_ld;
        core_gnt  = 2'b00;
        mem_en    = win_ld | win_core;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win_ld) begin
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (win_core) begin
            core_gnt[win_idx] = 1'b1;
            mem_we            = core_we[win_idx];
            mem_addr          = win_idx ? core_addr[REQ_C1*AW +: AW]
                                        : core_addr[REQ_C0*AW +: AW];
            mem_wdata         = win_idx ? core_wdata[REQ_C1*DW +: DW]
                                        : core_wdata[REQ_C0*DW +: DW];
        end
    end

    // Arbitration state and read-return pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q       <= OwnIdle;
            last_core_q <= 1'b1;
            cnt_q       <= '0;
            rv_q        <= 2'b00;
        end else begin
            own_q       <= own_d;
            last_core_q <= last_core_d;
            cnt_q       <= cnt_d;
            rv_q        <= core_gnt & ~core_we;
        end
    end

    // A read issued just before reset is dropped rather than returned.
    assign core_rvalid = reset ? 2'b00 : rv_q;
    assign rdata       = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_ld;
    logic [STAT_W-1:0] stat_c0;
    logic [STAT_W-1:0] stat_c1;

    mem_arb_sat_cnt u_stat_ld (
        .clk   (clk),
        .reset (reset),
        .inc   (ld_gnt),
        .count (stat_ld)
    );

    mem_arb_sat_cnt u_stat_c0 (
        .clk   (clk),
        .reset (reset),
        .inc   (core_gnt[REQ_C0]),
        .count (stat_c0)
    );

    mem_arb_sat_cnt u_stat_c1 (
        .clk   (clk),
        .reset (reset),
        .inc   (core_gnt[REQ_C1]),
        .count (stat_c1)
    );

    assign stat_gnt = {stat_ld, stat_c1, stat_c0};
`else
    assign stat_gnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// predicted by a behavioural arbitration model and checked by an independent monitor.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BURST = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic [1:0]    core_req;
    logic [1:0]    core_we;
    logic [2*AW-1:0] core_addr;
    logic [2*DW-1:0] core_wdata;
    logic [1:0]    core_gnt;
    logic [1:0]    core_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [47:0]   stat_gnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW    (AW),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_gnt      (ld_gnt),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .rdata       (rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stat_gnt    (stat_gnt)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endfunction

    // RAM with one-cycle read latency; filled on the first clock edge.
    logic [DW-1:0] ram [0:1023];
    logic          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[11:2]] <= mem_wdata;
        end
        mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr[11:2]] : 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic          ld_gnt;
        logic [1:0]    core_gnt;
        logic          mem_en;
        logic          mem_we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    rvalid;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the port, how long, who was served last.
    int            m_holder;   // -1 none, 0/1 core, 2 loader
    int            m_run;
    int            m_last;
    logic [1:0]    m_pend_rd;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] shadow [0:1023];
    int            m_ld_cnt;
    int            m_c0_cnt;
    int            m_c1_cnt;

    function automatic int model_step();
        exp_t e;
        int   w;
        e = '0;
        if (reset) begin
            m_holder  = -1;
            m_run     = 0;
            m_last    = 1;
            m_pend_rd = 2'b00;
            m_ld_cnt  = 0;
            m_c0_cnt  = 0;
            m_c1_cnt  = 0;
            sb.push_back(e);
            return -1;
        end
        e.rvalid  = m_pend_rd;
        e.rdata   = m_pend_data;
        m_pend_rd = 2'b00;
        w = -1;
        if (ld_req) w = 2;
        else if ((m_holder == 0 || m_holder == 1) && core_req[m_holder] &&
                 (m_run < BURST || !core_req[1-m_holder])) w = m_holder;
        else if (core_req == 2'b11) w = 1 - m_last;
        else if (core_req[0]) w = 0;
        else if (core_req[1]) w = 1;

        if (w == 2) begin
            e.ld_gnt = 1'b1;
            e.mem_en = 1'b1;
            e.mem_we = 1'b1;
            e.addr   = ld_addr;
            e.wdata  = ld_wdata;
            shadow[ld_addr[11:2]] = ld_wdata;
            m_holder = 2;
            m_run    = 0;
            m_ld_cnt++;
        end else if (w >= 0) begin
            e.core_gnt[w] = 1'b1;
            e.mem_en      = 1'b1;
            e.mem_we      = core_we[w];
            e.addr        = core_addr[w*AW +: AW];
            e.wdata       = core_wdata[w*DW +: DW];
            if (core_we[w]) shadow[e.addr[11:2]] = e.wdata;
            else begin
                m_pend_rd[w] = 1'b1;
                m_pend_data  = shadow[e.addr[11:2]];
            end
            m_run    = (m_holder == w) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_holder = w;
            m_last   = w;
            if (w == 0) m_c0_cnt++;
            else m_c1_cnt++;
        end else begin
            m_holder = -1;
            m_run    = 0;
        end
        sb.push_back(e);
        return w;
    endfunction

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                if (mem_en || (core_rvalid != 2'b00)) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_activity: got mem_en=%0b rvalid=%0b expected idle",
                             mem_en, core_rvalid);
                end
            end else begin
                e = sb.pop_front();
                check("ld_gnt", 64'(ld_gnt), 64'(e.ld_gnt));
                check("core_gnt", 64'(core_gnt), 64'(e.core_gnt));
                check("mem_en", 64'(mem_en), 64'(e.mem_en));
                check("mem_we", 64'(mem_we), 64'(e.mem_we));
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                check("core_rvalid", 64'(core_rvalid), 64'(e.rvalid));
                if (e.rvalid != 2'b00) check("rdata", 64'(rdata), 64'(e.rdata));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         w;
        int         last_w;
        int         ngnt;
        logic [1:0] pat;

        reset = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        core_req = 2'b00; core_we = 2'b00; core_addr = '0; core_wdata = '0;
        m_holder = -1; m_run = 0; m_last = 1; m_pend_rd = 2'b00; m_pend_data = '0;
        m_ld_cnt = 0; m_c0_cnt = 0; m_c1_cnt = 0;
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

        // Reset state.
        repeat (2) begin
            next_cycle();
            w = model_step();
        end
        #3;
        check("reset_mem_en", 64'(mem_en), 64'(0));
        check("reset_grants", 64'({ld_gnt, core_gnt}), 64'(0));
        check("reset_rvalid", 64'(core_rvalid), 64'(0));

        // Both cores reading continuously from reset: C0 x4, C1 x4, C0 x4.
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            reset = 1'b0;
            core_req = 2'b11;
            core_we = 2'b00;
            core_addr = {32'h20, 32'h10};
            w = model_step();
            #3;
            pat = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
            check("rr_burst_pattern", 64'(core_gnt), 64'(pat));
            if (k == 1) begin
                check("first_rvalid", 64'(core_rvalid), 64'(2'b01));
                check("first_rdata", 64'(rdata), 64'(init_word(4)));
            end
        end

        // Core1 alone writes 0x5 to 0x40 for six cycles: no burst limit.
        next_cycle();
        core_req = 2'b00; core_we = 2'b00;
        w = model_step();
        ngnt = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            core_req = 2'b10;
            core_we = 2'b10;
            core_addr[AW +: AW] = 32'h40;
            core_wdata[DW +: DW] = 32'h5;
            w = model_step();
            #3;
            if (core_gnt[1]) ngnt++;
        end
        next_cycle();
        core_req = 2'b00; core_we = 2'b00;
        w = model_step();
        check("c1_solo_grants", 64'(ngnt), 64'(6));
        check("c1_solo_ram", 64'(ram[16]), 64'(32'h5));

        // Loader preempts core0 mid-burst; the prior read still returns.
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            core_req = 2'b01; core_we = 2'b00;
            core_addr[0 +: AW] = 32'h30 + 32'(4 * k);
            w = model_step();
        end
        next_cycle();
        ld_req = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hCAFE_F00D;
        core_addr[0 +: AW] = 32'h38;
        w = model_step();
        #3;
        check("ld_preempt_gnt", 64'({ld_gnt, core_gnt}), 64'(3'b100));
        check("ld_preempt_we", 64'(mem_we), 64'(1));
        check("ld_preempt_addr", 64'(mem_addr), 64'(32'h100));
        check("ld_preempt_rvalid", 64'(core_rvalid), 64'(2'b01));
        // Core0 restarts its tenure at one, so it keeps four grants before core1.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            ld_req = 1'b0;
            core_req = (k == 0) ? 2'b01 : 2'b11;
            core_we = 2'b00;
            core_addr = {32'h24, 32'h38};
            w = model_step();
            #3;
            pat = (k == 4) ? 2'b10 : 2'b01;
            check("post_ld_burst", 64'(core_gnt), 64'(pat));
        end

        // Reset right after a core0 read grant discards the pending rvalid.
        next_cycle();
        core_req = 2'b00;
        w = model_step();
        next_cycle();
        core_req = 2'b01; core_we = 2'b00; core_addr[0 +: AW] = 32'h10;
        w = model_step();
        #3;
        check("pre_reset_gnt", 64'(core_gnt), 64'(2'b01));
        next_cycle();
        reset = 1'b1; core_req = 2'b00;
        w = model_step();
        #3;
        check("reset_drops_rvalid", 64'(core_rvalid), 64'(0));
        check("reset_no_mem_en", 64'(mem_en), 64'(0));
        next_cycle();
        reset = 1'b0; core_req = 2'b11; core_addr = {32'h20, 32'h10};
        w = model_step();
        #3;
        check("post_reset_gnt", 64'(core_gnt), 64'(2'b01));
        check("post_reset_rvalid", 64'(core_rvalid), 64'(0));
        last_w = w;

        // Randomized traffic; requesters hold their request until granted.
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            reset = ($urandom_range(0, 199) == 0);
            if (!(ld_req && last_w != 2)) begin
                ld_req = ($urandom_range(0, 9) == 0);
                ld_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                ld_wdata = $urandom;
            end
            for (int i = 0; i < 2; i++) begin
                if (!(core_req[i] && last_w != i)) begin
                    core_req[i] = ($urandom_range(0, 3) != 0);
                    core_we[i] = 1'($urandom_range(0, 1));
                    core_addr[i*AW +: AW] = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                    core_wdata[i*DW +: DW] = $urandom;
                end
            end
            last_w = model_step();
        end

        next_cycle();
`ifdef MEM_ARB_STATS_EN
        check("stat_gnt_counts", 64'(stat_gnt),
              64'({sat16(m_ld_cnt), sat16(m_c1_cnt), sat16(m_c0_cnt)}));
`else
        check("stat_gnt_tied_off", 64'(stat_gnt), 64'(0));
`endif
        reset = 1'b1; ld_req = 1'b0; core_req = 2'b00; core_we = 2'b00;
        w = model_step();

`ifdef MEM_ARB_STATS_EN
        // Loader counter saturation.
        for (int k = 0; k < 70000; k++) begin
            next_cycle();
            reset = 1'b0;
            ld_req = 1'b1;
            ld_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            ld_wdata = $urandom;
            w = model_step();
        end
        next_cycle();
        check("stat_ld_saturated", 64'(stat_gnt[47:32]), 64'(16'hFFFF));
        check("stat_gnt_after_sat", 64'(stat_gnt),
              64'({sat16(m_ld_cnt), sat16(m_c1_cnt), sat16(m_c0_cnt)}));
        ld_req = 1'b0;
        w = model_step();
`endif

        next_cycle();
        reset = 1'b0; ld_req = 1'b0; core_req = 2'b00;
        w = model_step();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port among three requesters: the external program loader, core0 and core1 (the BranchCPU-woken second core).
- The loader has absolute priority. The two cores are served round-robin, and each core may hold the port for a bounded burst of consecutive accesses.
- Sits between the cores' M-stage memory interfaces and the RAM's data port, which has 1-cycle read latency.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- BURST, 4, maximum consecutive grants one core keeps while the other core is waiting (legal range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_gnt  out  1  loader access issued this cycle.
- core_req  in  2  per-core request; bit i is core i.
- core_we  in  2  per-core write enable.
- core_addr  in  2*AW  core i address at [i*AW +: AW].
- core_wdata  in  2*DW  core i write data at [i*DW +: DW].
- core_gnt  out  2  core i access issued this cycle.
- core_rvalid  out  2  read data for core i valid on rdata this cycle.
- rdata  out  DW  read data, passed through from mem_rdata.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read is issued.
- stat_gnt  out  48  grant counters {ld, c1, c0}, 16 bits each (see Optional Feature).

Behaviour:
- Registered state:
  - own in {IDLE, LD, C0, C1}.
  - last_core (1 bit): last core served.
  - cnt (4 bits): grants in the current core tenure.
  - rv (2 bits): registered copy of core_rvalid.
- Selection is combinational each cycle, in priority order:
  1. If ld_req=1: the loader wins. mem_we=1. cnt is cleared. own becomes LD.
  2. Else if own=Ci and core_req[i]=1: core i keeps the port if cnt<BURST or core_req[~i]=0.
  3. Else, if exactly one core requests, that core wins. If both request, core ~last_core wins.
  4. Else there is no grant: mem_en=0 and own becomes IDLE.
- Exactly one grant is issued per cycle, at most.
  - The grant signal (ld_gnt or core_gnt[i]) equals mem_en for the winner, in the same cycle.
  - mem_addr, mem_wdata and mem_we are muxed from the winner. They are 0 when there is no grant.
- On a core grant:
  - If own already equals that core, cnt increments (saturating at 15).
  - Otherwise cnt is set to 1 and own changes to that core.
  - last_core is updated to the winning core.
- A tenure ends when the owner drops its request, or when cnt reaches BURST while the other core is requesting. The next cycle then grants the other core (no idle bubble).
- Read return: core_rvalid[i] = registered (core_gnt[i] & ~core_we[i]).
  - rdata = mem_rdata, combinationally.
  - Latency from grant to rvalid is exactly 1 cycle.
- Loader preemption:
  - Preempts any core tenure immediately.
  - A core read issued in the previous cycle still returns its rvalid.
  - After the loader drops ld_req, round-robin resumes with cnt=0. last_core is unchanged by loader grants.
- Simultaneous events:
  - Both cores first request in the same cycle from IDLE after reset: core0 wins (last_core resets to 1).
  - BURST=1 gives strict alternation whenever both cores request.
- Reset:
  - own=IDLE, last_core=1, cnt=0, core_rvalid=0, all grants 0, mem_en=0.
  - A pending rvalid at reset is discarded.
- Requesters hold req/addr/wdata stable until they see their gnt. The arbiter does not latch requests.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With the macro defined: three 16-bit saturating counters count ld_gnt, core_gnt[0] and core_gnt[1]. They are cleared by reset, stick at 16'hFFFF, and drive stat_gnt.
- Without the macro: stat_gnt is tied to 0 and no counter flops exist.

Decomposition:
- Shared package mem_arb_pkg holds:
  - own-state enum (IDLE=0, LD=1, C0=2, C1=3);
  - requester index constants (REQ_C0=0, REQ_C1=1);
  - STAT_W=16.
- One sub-module, mem_arb_sat_cnt: a STAT_W saturating counter with synchronous reset and increment enable. It is instantiated 3 times, only under MEM_ARB_STATS_EN.

Test Plan:
- Reset, then core_req=2'b11, both reading addr 0x10 and 0x20 → core_gnt=01 in cycle 0; core_rvalid=01 in cycle 1, with rdata = RAM[0x10].
- Both cores hold continuous reads, BURST=4 → grant pattern C0×4, C1×4, C0×4, with no idle cycle between tenures.
- core1 alone writes 0x5 to addr 0x40 for 6 cycles, core0 idle → 6 consecutive core_gnt[1] pulses (burst limit not applied); RAM[0x40]=0x5.
- core0 is mid-burst (cnt=2) and ld_req rises with addr 0x100 → ld_gnt=1 that cycle with mem_we=1; core0's read from the prior cycle still gets core_rvalid[0]=1; once ld_req drops, core0 restarts with cnt=1.
- reset is asserted in the cycle after a core0 read grant → core_rvalid[0]=0 next cycle; all outputs 0; next dual request grants core0 first.
- With MEM_ARB_STATS_EN defined, 70000 loader grants → stat_gnt[47:32]=16'hFFFF (saturated); without the macro, stat_gnt=0.
